// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared output-state type and bit-counter width helper for sipo_rx.
package sipo_rx_pkg;
  typedef enum logic {S_EMPTY, S_FULL} out_state_e;
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction
endpackage

// File: rtl/sipo_bit_cnt.sv
// sipo_bit_cnt: frame-length bit counter with strobe, sync clear and terminal-count pulse.
module sipo_bit_cnt
  import sipo_rx_pkg::*;
#(
  parameter int W     = 8,
  parameter int FRAME = W
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic stb,
  output logic tc
);
  localparam int CW = cnt_width(W);
  logic [CW-1:0] cnt_q, cnt_d;
  logic last;
  assign last  = cnt_q == CW'(FRAME - 1);
  assign tc    = stb & ~clr & last;
  assign cnt_d = clr ? '0 : !stb ? cnt_q : last ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-to-parallel receiver with double-buffered valid/ready output.
// Define SIPO_RX_PARITY_EN to append an even-parity bit to each frame and report perr.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         bit_vld,
  input  logic         bit_in,
  input  logic         out_rdy,
  output logic [W-1:0] data_out,
  output logic         out_vld,
  output logic         ovr,
  output logic         perr
);
`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif
  logic [W-1:0] sreg_q, sreg_d, word_d, data_q;
  out_state_e   state_q;
  logic         ovr_q, done, load, overrun;
  sipo_bit_cnt #(.W(W), .FRAME(FRAME)) u_cnt (
    .clk  (clk),
    .rst_b(rst_b),
    .clr  (clr),
    .stb  (bit_vld),
    .tc   (done)
  );
  assign sreg_d  = W'({bit_in, sreg_q} >> 1);
`ifdef SIPO_RX_PARITY_EN
  // The parity bit is the last one in; the data bits are already in place.
  assign word_d  = sreg_q;
`else
  assign word_d  = sreg_d;
`endif
  assign load    = done & (state_q == S_EMPTY | out_rdy);
  assign overrun = done & state_q == S_FULL & ~out_rdy;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sreg_q  <= '0;
      data_q  <= '0;
      state_q <= S_EMPTY;
      ovr_q   <= 1'b0;
    end else if (clr) begin
      sreg_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (bit_vld) sreg_q <= sreg_d;
      if (overrun) ovr_q <= 1'b1;
      if (load) begin
        data_q  <= word_d;
        state_q <= S_FULL;
      end else if (out_rdy) begin
        state_q <= S_EMPTY;
      end
    end
  end
`ifdef SIPO_RX_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b)    perr_q <= 1'b0;
    else if (load) perr_q <= ^{bit_in, sreg_q};
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif
  assign data_out = data_q;
  assign out_vld  = state_q == S_FULL;
  assign ovr      = ovr_q;
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed self-checking bench for sipo_rx (W=8), parity checks under SIPO_RX_PARITY_EN.
module tb_sipo_rx;
  logic       clk = 1'b0;
  logic       rst_b, clr, bit_vld, bit_in, out_rdy;
  logic [7:0] data_out;
  logic       out_vld, ovr, perr;
  int         vectors = 0;
  int         miscompares = 0;
`ifdef SIPO_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  sipo_rx #(.W(8)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (clr),
    .bit_vld (bit_vld),
    .bit_in  (bit_in),
    .out_rdy (out_rdy),
    .data_out(data_out),
    .out_vld (out_vld),
    .ovr     (ovr),
    .perr    (perr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bit_vld = 1'b1;
    bit_in  = b;
    tick();
    bit_vld = 1'b0;
    bit_in  = 1'b0;
  endtask
  // Sends one frame LSB first; pflip corrupts the parity bit, rdy_last raises out_rdy for the final bit.
  task automatic send_word(input logic [7:0] v, input logic pflip, input logic rdy_last);
    logic [8:0] f;
    f = {^v ^ pflip, v};
    for (int i = 0; i < NBITS; i++) begin
      if (i == NBITS - 1 && rdy_last) out_rdy = 1'b1;
      send_bit(f[i]);
    end
  endtask
  task automatic accept();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask
  initial begin
    rst_b = 1'b0; clr = 1'b0; bit_vld = 1'b0; bit_in = 1'b0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_vld", 32'(out_vld), 32'h0);
    check("rst_ovr", 32'(ovr), 32'h0);
    check("rst_perr", 32'(perr), 32'h0);
    rst_b = 1'b1;
    tick();
    send_word(8'hAA, 1'b0, 1'b0);
    check("aa_data", 32'(data_out), 32'hAA);
    check("aa_vld", 32'(out_vld), 32'h1);
    check("aa_perr", 32'(perr), 32'h0);
    accept();
    check("aa_acc_vld", 32'(out_vld), 32'h0);
    out_rdy = 1'b1;
    send_word(8'hF0, 1'b0, 1'b0);
    check("b2b_f0_data", 32'(data_out), 32'hF0);
    check("b2b_f0_vld", 32'(out_vld), 32'h1);
    send_word(8'h0F, 1'b0, 1'b0);
    check("b2b_0f_data", 32'(data_out), 32'h0F);
    check("b2b_0f_vld", 32'(out_vld), 32'h1);
    check("b2b_ovr", 32'(ovr), 32'h0);
    tick();
    out_rdy = 1'b0;
    check("b2b_drain_vld", 32'(out_vld), 32'h0);
    send_word(8'h11, 1'b0, 1'b0);
    check("full_11_data", 32'(data_out), 32'h11);
    send_word(8'h22, 1'b0, 1'b1);
    out_rdy = 1'b0;
    check("full_rdy_data", 32'(data_out), 32'h22);
    check("full_rdy_vld", 32'(out_vld), 32'h1);
    check("full_rdy_ovr", 32'(ovr), 32'h0);
    accept();
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b0);
    check("ovr_data", 32'(data_out), 32'h3C);
    check("ovr_flag", 32'(ovr), 32'h1);
    check("ovr_vld", 32'(out_vld), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovr", 32'(ovr), 32'h0);
    check("clr_data", 32'(data_out), 32'h3C);
    check("clr_vld", 32'(out_vld), 32'h1);
    accept();
    check("ovr_acc_vld", 32'(out_vld), 32'h0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    clr = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
    tick();
    clr = 1'b0; bit_vld = 1'b0; bit_in = 1'b0;
    send_word(8'h81, 1'b0, 1'b0);
    check("flush_data", 32'(data_out), 32'h81);
    check("flush_vld", 32'(out_vld), 32'h1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst_b = 1'b0;
    #1;
    check("midrst_data", 32'(data_out), 32'h0);
    check("midrst_vld", 32'(out_vld), 32'h0);
    tick();
    rst_b = 1'b1;
    tick();
    send_word(8'h5A, 1'b0, 1'b0);
    check("postrst_data", 32'(data_out), 32'h5A);
    check("postrst_vld", 32'(out_vld), 32'h1);
    accept();
`ifdef SIPO_RX_PARITY_EN
    send_word(8'hAA, 1'b0, 1'b0);
    check("par_ok_data", 32'(data_out), 32'hAA);
    check("par_ok_perr", 32'(perr), 32'h0);
    accept();
    send_word(8'hAA, 1'b1, 1'b0);
    check("par_bad_data", 32'(data_out), 32'hAA);
    check("par_bad_perr", 32'(perr), 32'h1);
    accept();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver: the far end of the team's parallel-load/shift-right serializer. Collects one bit per strobed cycle, LSB first, assembles a `W`-bit word and presents it on a registered valid/ready output port. Double-buffered: the shift register keeps filling while a completed word waits to be accepted. Sits between a serial link and any word-wide consumer in the datapath.

## Interface
- `W`, default 8, word width in bits (≥ 2)
- `clk`  in  1  clock, all state updates on rising edge
- `rst_b`  in  1  asynchronous active-low reset
- `clr`  in  1  synchronous flush, active high; drops partial word, clears `ovr`
- `bit_vld`  in  1  strobe, `bit_in` sampled on this edge when high
- `bit_in`  in  1  serial data bit, LSB of word first
- `out_rdy`  in  1  consumer accepts `data_out` when high with `out_vld`
- `data_out`  out  `W`  assembled word, registered
- `out_vld`  out  1  `data_out` holds an unaccepted word
- `ovr`  out  1  sticky overrun flag
- `perr`  out  1  parity error for the word in `data_out` (see Configuration)

## Operation
- Priority: `rst_b` > `clr` > `bit_vld`/`out_rdy`.
- Reset: `data_out`=0, `out_vld`=0, `ovr`=0, `perr`=0, bit counter=0, shift register=0. All outputs driven, never Z.
- Shift: on `bit_vld`, `sreg <= {bit_in, sreg[W-1:1]}`, counter increments. Non-strobed cycles hold state; gaps between bits are legal.
- Completion: edge sampling the last frame bit transfers `{bit_in, sreg[W-1:1]}` to `data_out`, counter wraps to 0.
- Output FSM (2 states): `S_EMPTY` (`out_vld`=0) -> `S_FULL` on completion. `S_FULL` -> `S_EMPTY` on `out_rdy` without completion. `S_FULL` stays `S_FULL` on completion + `out_rdy` (new word replaces accepted one, no overrun).
- Overrun: completion in `S_FULL` with `out_rdy`=0 -> new word discarded, `data_out` unchanged, `ovr` set; stays set until `clr` or reset.
- `clr`: counter=0, `sreg`=0, `ovr`=0; `data_out`/`out_vld` untouched (a completed word survives a flush). `bit_vld` in the same cycle is ignored.
- Reset mid-word: partial word lost, first bit after release is bit 0.

## Timing
- Latency: `out_vld` rises the cycle after the edge sampling the last bit (0 extra cycles).
- Throughput: one bit per cycle sustained; back-to-back words with no gap are legal.
- Handshake: transfer on edge where `out_vld & out_rdy`; `data_out` stable while `out_vld`=1 and not accepted. `out_rdy` may be high while `out_vld`=0 (no effect).
- Counter width `$clog2(W+2)`; wraps exactly at frame length, never saturates.

## Configuration
- `SIPO_RX_PARITY_EN` defined: frame is `W+1` bits; bit `W` (last) is even parity over the data bits and is not stored. `perr` registered together with `data_out`: 1 if XOR of the `W+1` received bits ≠ 0. On overrun, `perr` is not updated.
- Undefined: frame is `W` bits, `perr` tied to 0.

## Structure
- Package `sipo_rx_pkg`: output state typedef (`S_EMPTY`, `S_FULL`), counter width function.
- One sub-module: `sipo_bit_cnt` (frame-length counter with strobe, sync clear, wrap/terminal-count output). Shift register, output register and FSM stay in `sipo_rx`.

## Test plan
- Reset: `rst_b`=0 mid-simulation -> all outputs 0, next 8 strobed bits form a fresh word.
- Single word, W=8: bits 0,1,0,1,0,1,0,1 with `bit_vld`=1 -> next cycle `data_out`=8'hAA, `out_vld`=1; `out_rdy` pulse -> `out_vld`=0.
- Back-to-back with `out_rdy`=1 held: 8'hF0 then 8'h0F LSB first, no gaps -> two accepted words, `ovr`=0.
- Overrun: 8'h3C completed, `out_rdy`=0, then 8'h55 completed -> `data_out`=8'h3C, `ovr`=1; `clr` -> `ovr`=0, `data_out` still 8'h3C.
- Flush mid-word: 3 bits then `clr`, then 8 bits of 8'h81 -> `data_out`=8'h81.
- Parity (`SIPO_RX_PARITY_EN`): 8'hAA + parity 0 -> `perr`=0; 8'hAA + parity 1 -> `perr`=1.
